// File: rtl/hdmi_stream_tracker.sv
// Aligns decoded HDMI pixels to frame/line coordinates and tracks active geometry.
// Raises locked once LOCK_FRAMES consecutive frames share the same width and height.
module hdmi_stream_tracker #(
  parameter int   ADDR_BITS   = 12,
  parameter int   DATA_BITS   = 8,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic                 hdmi_clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [1:0]           sync,
  input  logic                 de,
  input  logic [DATA_BITS-1:0] d0,
  input  logic [DATA_BITS-1:0] d1,
  input  logic [DATA_BITS-1:0] d2,
  output logic [ADDR_BITS-1:0] xaddr,
  output logic [ADDR_BITS-1:0] yaddr,
  output logic                 rgb_valid,
  output logic [DATA_BITS-1:0] r,
  output logic [DATA_BITS-1:0] g,
  output logic [DATA_BITS-1:0] b,
  output logic                 frame_start,
  output logic                 line_start,
  output logic [ADDR_BITS-1:0] width,
  output logic [ADDR_BITS-1:0] height,
  output logic                 locked
);
  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [ADDR_BITS-1:0] AMAX  = '1;
  localparam logic [ADDR_BITS-1:0] ONE_A = 1;
  localparam logic [ADDR_BITS:0]   ONE_W = 1;

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;
  state_t state_q, state_d, st;

  logic hs_q, hs_d, hs_p_q, hs_p_d, vs_q, vs_d, vs_p_q, vs_p_d;
  logic aligned_q, aligned_d, new_frame_q, new_frame_d, new_line_q, new_line_d;
  logic [ADDR_BITS-1:0] x_q, x_d, y_q, y_d, width_q, width_d, height_q, height_d;
  logic rgb_valid_q, rgb_valid_d, frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic [DATA_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic line_px_q, line_px_d, frame_px_q, frame_px_d;
  logic have_first_q, have_first_d, frame_bad_q, frame_bad_d;
  logic [ADDR_BITS:0] first_w_q, first_w_d, ref_w_q, ref_w_d, ref_h_q, ref_h_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic hs_edge, vs_edge, pix, line_end, frame_end, mism, frame_ok;
  logic [ADDR_BITS:0] line_w, frame_h, frame_w;

  assign hs_edge   = hs_q & ~hs_p_q;
  assign vs_edge   = vs_q & ~vs_p_q;
  assign pix       = valid & de & aligned_q;
  // widths are one bit wider so a saturated 2^ADDR_BITS-1 coordinate still yields its true +1 size
  assign line_w    = {1'b0, x_q} + ONE_W;
  assign frame_h   = {1'b0, y_q} + ONE_W;
  assign line_end  = hs_edge & line_px_q;
  assign frame_end = vs_edge & frame_px_q;
  assign mism      = have_first_q & (line_w != first_w_q);
  // a line ending on the same cycle as the frame is folded into this frame's verdict
  assign frame_ok  = ~frame_bad_q & ~(line_end & mism);
  assign frame_w   = have_first_q ? first_w_q : line_w;

  always_comb begin
    hs_d = (sync[0] == HSYNC_POL);  hs_p_d = hs_q;
    vs_d = (sync[1] == VSYNC_POL);  vs_p_d = vs_q;
    aligned_d = aligned_q;  new_frame_d = new_frame_q;  new_line_d = new_line_q;
    x_d = x_q;  y_d = y_q;  width_d = width_q;  height_d = height_q;
    r_d = d2;  g_d = d1;  b_d = d0;
    rgb_valid_d   = pix;
    frame_start_d = pix & new_frame_q;
    line_start_d  = pix & (new_frame_q | new_line_q);
    line_px_d = line_px_q;  frame_px_d = frame_px_q;
    have_first_d = have_first_q;  frame_bad_d = frame_bad_q;  first_w_d = first_w_q;
    ref_w_d = ref_w_q;  ref_h_d = ref_h_q;  cnt_d = cnt_q;
    st = state_q;

    if (pix) begin
      line_px_d  = 1'b1;
      frame_px_d = 1'b1;
      if (new_frame_q) begin
        x_d = '0;  y_d = '0;  new_frame_d = 1'b0;  new_line_d = 1'b0;
      end else if (new_line_q) begin
        x_d = '0;  y_d = (y_q == AMAX) ? y_q : y_q + ONE_A;  new_line_d = 1'b0;
      end else begin
        x_d = (x_q == AMAX) ? x_q : x_q + ONE_A;
      end
    end

    if (hs_edge) begin
      new_line_d = 1'b1;
      line_px_d  = 1'b0;
    end
    if (line_end) begin
      if (!have_first_q) begin
        first_w_d = line_w;  have_first_d = 1'b1;
      end else if (mism) begin
        frame_bad_d = 1'b1;
      end
      if (state_q == LOCKED && line_w != ref_w_q) st = HUNT;
    end
    state_d = st;

    if (vs_edge) begin
      new_frame_d = 1'b1;  aligned_d = 1'b1;
      frame_px_d = 1'b0;  have_first_d = 1'b0;  frame_bad_d = 1'b0;
    end
    if (frame_end) begin
      case (st)
        HUNT: begin
          ref_w_d = frame_w;  ref_h_d = frame_h;  cnt_d = CW'(1);  state_d = CHECK;
        end
        CHECK: begin
          if (frame_ok && frame_w == ref_w_q && frame_h == ref_h_q) begin
            if (int'(cnt_q) + 1 >= LOCK_FRAMES) begin
              cnt_d = CW'(LOCK_FRAMES);  state_d = LOCKED;
              width_d = ref_w_q[ADDR_BITS-1:0];  height_d = ref_h_q[ADDR_BITS-1:0];
            end else begin
              cnt_d = CW'(int'(cnt_q) + 1);
            end
          end else begin
            ref_w_d = frame_w;  ref_h_d = frame_h;  cnt_d = CW'(1);
          end
        end
        default: if (frame_h != ref_h_q) state_d = HUNT;
      endcase
    end

    // losing symbol lock drops alignment and all per-frame tracking; geometry outputs survive
    if (!valid) begin
      rgb_valid_d = 1'b0;  frame_start_d = 1'b0;  line_start_d = 1'b0;
      aligned_d = 1'b0;  new_frame_d = 1'b0;  new_line_d = 1'b0;
      line_px_d = 1'b0;  frame_px_d = 1'b0;  have_first_d = 1'b0;  frame_bad_d = 1'b0;
      cnt_d = '0;  state_d = HUNT;
    end
  end

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      hs_q <= 1'b0;  hs_p_q <= 1'b0;  vs_q <= 1'b0;  vs_p_q <= 1'b0;
      aligned_q <= 1'b0;  new_frame_q <= 1'b0;  new_line_q <= 1'b0;
      x_q <= '0;  y_q <= '0;  width_q <= '0;  height_q <= '0;
      rgb_valid_q <= 1'b0;  frame_start_q <= 1'b0;  line_start_q <= 1'b0;
      r_q <= '0;  g_q <= '0;  b_q <= '0;
      line_px_q <= 1'b0;  frame_px_q <= 1'b0;  have_first_q <= 1'b0;  frame_bad_q <= 1'b0;
      first_w_q <= '0;  ref_w_q <= '0;  ref_h_q <= '0;  cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hs_q <= hs_d;  hs_p_q <= hs_p_d;  vs_q <= vs_d;  vs_p_q <= vs_p_d;
      aligned_q <= aligned_d;  new_frame_q <= new_frame_d;  new_line_q <= new_line_d;
      x_q <= x_d;  y_q <= y_d;  width_q <= width_d;  height_q <= height_d;
      rgb_valid_q <= rgb_valid_d;  frame_start_q <= frame_start_d;  line_start_q <= line_start_d;
      r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
      line_px_q <= line_px_d;  frame_px_q <= frame_px_d;
      have_first_q <= have_first_d;  frame_bad_q <= frame_bad_d;
      first_w_q <= first_w_d;  ref_w_q <= ref_w_d;  ref_h_q <= ref_h_d;  cnt_q <= cnt_d;
    end
  end

  assign xaddr = x_q;  assign yaddr = y_q;
  assign rgb_valid = rgb_valid_q;
  assign r = r_q;  assign g = g_q;  assign b = b_q;
  assign frame_start = frame_start_q;  assign line_start = line_start_q;
  assign width = width_q;  assign height = height_q;
  assign locked = (state_q == LOCKED);
endmodule

// File: tb/tb_hdmi_stream_tracker.sv
// Drives two trackers (active-low and active-high sync) with the same random video and
// checks them against a frame/line-level reference model and a pixel scoreboard.
module tb_hdmi_stream_tracker;
  localparam int AB = 12, DB = 8, LF = 2, AMAX = 4095;

  logic clk = 0, rst = 1, valid = 1, de = 0, hs = 0, vs = 0;
  logic [DB-1:0] d0 = 0, d1 = 0, d2 = 0;
  logic [AB-1:0] xa[2], ya[2], wd[2], ht[2];
  logic [DB-1:0] rr[2], gg[2], bb[2];
  logic rv[2], fs[2], ls[2], lk[2];
  int n_chk = 0, n_pass = 0;
  logic [63:0] exq0[$], exq1[$];

  // reference model state
  bit m_al = 0, m_nf = 0, f_px = 0, fw_set = 0, fok = 1;
  int m_st = 0, m_cnt = 0, m_rw = 0, m_rh = 0, m_w = 0, m_h = 0, m_y = 0, fw = 0;

  hdmi_stream_tracker #(.ADDR_BITS(AB), .DATA_BITS(DB), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .LOCK_FRAMES(LF)) u_dut0 (
    .hdmi_clk(clk), .reset(rst), .valid(valid), .sync(~{vs, hs}), .de(de),
    .d0(d0), .d1(d1), .d2(d2), .xaddr(xa[0]), .yaddr(ya[0]), .rgb_valid(rv[0]),
    .r(rr[0]), .g(gg[0]), .b(bb[0]), .frame_start(fs[0]), .line_start(ls[0]),
    .width(wd[0]), .height(ht[0]), .locked(lk[0]));

  hdmi_stream_tracker #(.ADDR_BITS(AB), .DATA_BITS(DB), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .LOCK_FRAMES(LF)) u_dut1 (
    .hdmi_clk(clk), .reset(rst), .valid(valid), .sync({vs, hs}), .de(de),
    .d0(d0), .d1(d1), .d2(d2), .xaddr(xa[1]), .yaddr(ya[1]), .rgb_valid(rv[1]),
    .r(rr[1]), .g(gg[1]), .b(bb[1]), .frame_start(fs[1]), .line_start(ls[1]),
    .width(wd[1]), .height(ht[1]), .locked(lk[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pk(int x, int y, logic [7:0] r, logic [7:0] g,
                                     logic [7:0] b, bit f, bit l);
    return {14'd0, 12'(x), 12'(y), r, g, b, f, l};
  endfunction

  function automatic logic [63:0] obs(int k);
    return pk(xa[k], ya[k], rr[k], gg[k], bb[k], fs[k], ls[k]);
  endfunction

  always @(negedge clk) if (!rst) begin
    if (rv[0]) begin
      if (exq0.size() == 0) chk("spur0", rv[0], 0);
      else chk("pix0", obs(0), exq0.pop_front());
    end else if (fs[0] | ls[0]) chk("strobe0", {fs[0], ls[0]}, 0);
    if (rv[1]) begin
      if (exq1.size() == 0) chk("spur1", rv[1], 0);
      else chk("pix1", obs(1), exq1.pop_front());
    end else if (fs[1] | ls[1]) chk("strobe1", {fs[1], ls[1]}, 0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic zero_chk(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(tag, obs(k), 0);
      chk(tag, {rv[k], wd[k], ht[k], lk[k]}, 0);
    end
  endtask

  task automatic lock_chk();
    for (int k = 0; k < 2; k++) begin
      chk("locked", lk[k], m_st == 2);
      chk("width", wd[k], m_w);
      chk("height", ht[k], m_h);
    end
  endtask

  function automatic void m_loss();
    m_al = 0; m_nf = 0; m_st = 0; m_cnt = 0; f_px = 0; fw_set = 0; fok = 1;
  endfunction

  // geometry rules applied once per frame that carried pixels
  function automatic void m_frame_end();
    int fh;
    if (f_px) begin
      fh = m_y + 1;
      case (m_st)
        0: begin m_rw = fw; m_rh = fh; m_cnt = 1; m_st = 1; end
        1: if (fok && fw == m_rw && fh == m_rh) begin
             m_cnt++;
             if (m_cnt >= LF) begin m_st = 2; m_w = m_rw; m_h = m_rh; end
           end else begin
             m_rw = fw; m_rh = fh; m_cnt = 1;
           end
        default: if (fh != m_rh) m_st = 0;
      endcase
    end
    f_px = 0; fw_set = 0; fok = 1;
  endfunction

  function automatic void m_line_end(int lw);
    if (!fw_set) begin fw = lw; fw_set = 1; end
    else if (lw != fw) fok = 0;
    if (m_st == 2 && lw != m_rw) m_st = 0;
  endfunction

  // one line: npx de cycles, 2 porch, 3 hsync, rest blank; optional valid glitch / reset
  task automatic drive_line(input int npx, input int htot, input bit vsy,
                            input int glitch_at, input int rst_at);
    bit lp = 0;
    if (vsy && !vs) begin m_frame_end(); m_al = 1; m_nf = 1; end
    for (int i = 0; i < htot; i++) begin
      if (i == rst_at) begin
        rst = 1; #1;
        zero_chk("rst_mid");
        exq0.delete(); exq1.delete();
        m_loss(); m_w = 0; m_h = 0; lp = 0;
        rst = 0;
      end
      de = (i < npx); hs = (i >= npx + 2 && i < npx + 5); vs = vsy;
      valid = (i != glitch_at);
      if (de) {d2, d1, d0} = 24'($urandom);
      if (!valid) begin
        m_loss(); lp = 0;
      end else if (de && m_al) begin
        bit f = 0;
        if (i == 0) begin
          if (m_nf) begin m_y = 0; f = 1; m_nf = 0; end
          else if (m_y < AMAX) m_y++;
        end
        exq0.push_back(pk((i > AMAX) ? AMAX : i, m_y, d2, d1, d0, f, i == 0));
        exq1.push_back(pk((i > AMAX) ? AMAX : i, m_y, d2, d1, d0, f, i == 0));
        lp = 1; f_px = 1;
      end
      tick();
    end
    valid = 1;
    if (lp) m_line_end((npx > AMAX + 1) ? AMAX + 1 : npx);
    lock_chk();
  endtask

  task automatic vblank(input int htot);
    drive_line(0, htot, 0, -1, -1);
    drive_line(0, htot, 1, -1, -1);
    drive_line(0, htot, 1, -1, -1);
    drive_line(0, htot, 0, -1, -1);
  endtask

  task automatic frame(input int w, input int h, input int bad_line, input int bad_w,
                       input int gl_line, input int gl_px, input int rs_line, input int rs_px);
    int htot;
    htot = ((bad_w > w) ? bad_w : w) + 8;
    vblank(htot);
    for (int l = 0; l < h; l++)
      drive_line((l == bad_line) ? bad_w : w, htot, 0,
                 (l == gl_line) ? gl_px : -1, (l == rs_line) ? rs_px : -1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int w, h;
    repeat (3) @(posedge clk);
    #1;
    zero_chk("reset");
    rst = 0;
    w = $urandom_range(8, 20);
    h = $urandom_range(3, 6);
    repeat (3) frame(w, h, -1, 0, -1, -1, -1, -1);
    frame(w, h, 1, w / 2, -1, -1, -1, -1);
    repeat (2) frame(w, h, -1, 0, -1, -1, -1, -1);
    frame(w, h, -1, 0, 1, 3, -1, -1);
    repeat (2) frame(w, h, -1, 0, -1, -1, -1, -1);
    frame(w, h, -1, 0, -1, -1, 2, 4);
    repeat (2) frame(w, h, -1, 0, -1, -1, -1, -1);
    frame(5000, 2, -1, 0, -1, -1, -1, -1);
    chk("xsat", xa[0], AMAX);
    frame(w, h, -1, 0, -1, -1, -1, -1);
    vblank(w + 8);
    repeat (3) tick();
    chk("drain0", exq0.size(), 0);
    chk("drain1", exq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
